// File: rtl/block_check_ctrl.sv
// Round-robin front end for the shared block checker: grants one source per message,
// streams its chars into the checker, returns the verdict and clears the checker.
module block_check_ctrl #(
  parameter int MAX_LEN    = 1024,
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s0_valid,
  input  logic [7:0] s0_data,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic       s1_valid,
  input  logic [7:0] s1_data,
  input  logic       s1_last,
  output logic       s1_ready,
  output logic       chk_en,
  output logic [7:0] chk_data,
  output logic       chk_clr,
  input  logic       chk_result,
  output logic [1:0] done,
  output logic       verdict,
  output logic       overflow,
  output logic       busy
);

  localparam int SET_W = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] LEN_LAST   = CNT_W'(MAX_LEN - 1);
  localparam logic [SET_W-1:0] SETTLE_END = SET_W'(SETTLE_CYC);

  typedef enum logic [2:0] {IDLE, STREAM, SETTLE, REPORT, DRAIN, CLEAR} state_t;

  state_t           state;
  logic             owner;
  logic             ptr;
  logic [CNT_W-1:0] count;
  logic [SET_W-1:0] settle_cnt;

  logic       grant_owner;
  logic       sel_valid;
  logic [7:0] sel_data;
  logic       sel_last;
  logic       sel_ready;
  logic       accept;
  logic [1:0] owner_hot;

  // Pointer only breaks ties; a lone requester is always granted.
  assign grant_owner = (s0_valid && s1_valid) ? ptr : s1_valid;
  assign sel_valid   = owner ? s1_valid : s0_valid;
  assign sel_data    = owner ? s1_data  : s0_data;
  assign sel_last    = owner ? s1_last  : s0_last;
  assign sel_ready   = owner ? s1_ready : s0_ready;
  assign accept      = sel_valid && sel_ready;
  assign owner_hot   = owner ? 2'b10 : 2'b01;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      ptr        <= 1'b0;
      count      <= '0;
      settle_cnt <= '0;
      s0_ready   <= 1'b0;
      s1_ready   <= 1'b0;
      chk_en     <= 1'b0;
      chk_data   <= 8'd0;
      chk_clr    <= 1'b0;
      done       <= 2'b00;
      verdict    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      chk_en  <= 1'b0;
      chk_clr <= 1'b0;
      done    <= 2'b00;
      case (state)
        IDLE: begin
          if (s0_valid || s1_valid) begin
            owner    <= grant_owner;
            ptr      <= ~grant_owner;
            count    <= '0;
            s0_ready <= ~grant_owner;
            s1_ready <= grant_owner;
            state    <= STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            count <= count + CNT_W'(1);
            if (sel_last) begin
              chk_en     <= 1'b1;
              chk_data   <= sel_data;
              s0_ready   <= 1'b0;
              s1_ready   <= 1'b0;
              settle_cnt <= '0;
              state      <= SETTLE;
            end else if (count == LEN_LAST) begin
              // The char that hits the limit without last is dropped, not forwarded.
              overflow <= 1'b1;
              verdict  <= 1'b0;
              done     <= owner_hot;
              s0_ready <= 1'b0;
              s1_ready <= 1'b0;
              state    <= REPORT;
            end else begin
              chk_en   <= 1'b1;
              chk_data <= sel_data;
            end
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_END) begin
            verdict  <= chk_result;
            overflow <= 1'b0;
            done     <= owner_hot;
            state    <= REPORT;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end
        REPORT: begin
          if (overflow) begin
            s0_ready <= ~owner;
            s1_ready <= owner;
            state    <= DRAIN;
          end else begin
            chk_clr <= 1'b1;
            state   <= CLEAR;
          end
        end
        DRAIN: begin
          if (accept && sel_last) begin
            s0_ready <= 1'b0;
            s1_ready <= 1'b0;
            chk_clr  <= 1'b1;
            state    <= CLEAR;
          end
        end
        CLEAR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_check_ctrl.sv
// Bench for block_check_ctrl: table of messages plus contention and reset sequences,
// with a char/verdict scoreboard and a small counting checker model.
module tb_block_check_ctrl;

  localparam int MAX_LEN    = 9;
  localparam int CNT_W      = 16;
  localparam int SETTLE_CYC = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       s0_valid, s0_last, s0_ready;
  logic [7:0] s0_data;
  logic       s1_valid, s1_last, s1_ready;
  logic [7:0] s1_data;
  logic       chk_en, chk_clr, chk_result;
  logic [7:0] chk_data;
  logic [1:0] done;
  logic       verdict, overflow, busy;

  always #5 clk = ~clk;

  block_check_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .SETTLE_CYC(SETTLE_CYC)) dut (
    .clk(clk), .reset(reset),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_last(s0_last), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_last(s1_last), .s1_ready(s1_ready),
    .chk_en(chk_en), .chk_data(chk_data), .chk_clr(chk_clr), .chk_result(chk_result),
    .done(done), .verdict(verdict), .overflow(overflow), .busy(busy)
  );

  // Checker model: verdict is 1 when it has consumed exactly 'target' chars since clear.
  int mcnt;
  int target = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset)       mcnt <= 0;
    else if (chk_clr) mcnt <= 0;
    else if (chk_en)  mcnt <= mcnt + 1;
  end
  assign chk_result = (mcnt == target);

  typedef struct { logic [1:0] done; bit verdict; bit ovf; } rep_t;
  typedef struct {
    bit src; string text; int gap_at; int gap_len; bit chk_ok;
    bit exp_v; bit exp_o; int exp_nfwd; int exp_busy;
  } vec_t;

  byte unsigned exp_chars[$];
  rep_t         exp_reps[$];
  vec_t         vecs[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cyc, clr_cyc, busy_cnt, en_cnt, rep_acc, last_acc;
  int done_cyc_src[2];
  int first_acc[2];
  bit sb_chars = 1'b1;
  byte unsigned e_ch;
  rep_t e_rep;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (chk_clr) clr_cyc = cyc;
    check("en_clr_exclusive", {31'd0, chk_en & chk_clr}, 0);
    check("ready_exclusive", {31'd0, s0_ready & s1_ready}, 0);
    if (chk_en && sb_chars) begin
      en_cnt++;
      if (exp_chars.size() == 0) check("chk_en_unexpected", 1, 0);
      else begin
        e_ch = exp_chars.pop_front();
        check("chk_data", {24'd0, chk_data}, {24'd0, e_ch});
      end
    end
    if (done != 2'b00) begin
      if (exp_reps.size() == 0) check("done_unexpected", {30'd0, done}, 0);
      else begin
        e_rep = exp_reps.pop_front();
        check("done", {30'd0, done}, {30'd0, e_rep.done});
        check("verdict", {31'd0, verdict}, {31'd0, e_rep.verdict});
        check("overflow", {31'd0, overflow}, {31'd0, e_rep.ovf});
        done_cyc = cyc;
        done_cyc_src[done[1]] = cyc;
      end
    end
  end

  task automatic drive(input bit src, input bit v, input byte unsigned d, input bit l);
    if (src) begin s1_valid = v; s1_data = d; s1_last = l; end
    else     begin s0_valid = v; s0_data = d; s0_last = l; end
  endtask

  function automatic bit rdy(input bit src);
    return src ? s1_ready : s0_ready;
  endfunction

  task automatic send_msg(input bit src, input string text, input int gap_at, input int gap_len,
                          input bit chk_ok, input bit exp_v, input bit exp_o, input int nfwd);
    int   n = text.len();
    bit   ovf = 1'b0;
    rep_t r;
    r.done = src ? 2'b10 : 2'b01;
    r.verdict = exp_v;
    r.ovf = exp_o;
    for (int i = 0; i < n; i++) begin
      bit lst = (i == n - 1);
      int w = 0;
      if (gap_at > 0 && i == gap_at && gap_len > 0) begin
        drive(src, 1'b0, 8'd0, 1'b0);
        repeat (gap_len) @(posedge clk);
        #1;
      end
      drive(src, 1'b1, text[i], lst);
      @(negedge clk);
      while (!rdy(src) && w < 300) begin @(negedge clk); w++; end
      if (!rdy(src)) begin
        check("ready_timeout", 0, 1);
        drive(src, 1'b0, 8'd0, 1'b0);
        return;
      end
      if (i == 0) begin
        first_acc[src] = cyc;
        target = chk_ok ? nfwd : nfwd + 1;
      end
      if (!ovf) begin
        if (lst) begin
          exp_chars.push_back(text[i]);
          exp_reps.push_back(r);
          rep_acc = cyc;
        end else if (i == MAX_LEN - 1) begin
          ovf = 1'b1;
          exp_reps.push_back(r);
          rep_acc = cyc;
        end else begin
          exp_chars.push_back(text[i]);
        end
      end
      if (lst) last_acc = cyc;
      @(posedge clk);
      #1;
    end
    drive(src, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic wait_idle();
    int w = 0;
    do begin @(negedge clk); w++; end while (busy && w < 200);
    check("idle_timeout", {31'd0, busy}, 0);
    check("chars_drained", exp_chars.size(), 0);
    check("reps_drained", exp_reps.size(), 0);
  endtask

  task automatic contend(input bit first);
    fork
      send_msg(1'b0, "if end", 0, 0, 1'b1, 1'b1, 1'b0, 6);
      send_msg(1'b1, "do end", 0, 0, 1'b1, 1'b1, 1'b0, 6);
    join
    wait_idle();
    check("grant_order", {31'd0, first_acc[!first] > done_cyc_src[first]}, 1);
  endtask

  function automatic vec_t mk(input bit src, input string text, input int gap_at, input int gap_len,
                              input bit chk_ok, input bit exp_v, input bit exp_o,
                              input int exp_nfwd, input int exp_busy);
    vec_t v;
    v.src = src; v.text = text; v.gap_at = gap_at; v.gap_len = gap_len; v.chk_ok = chk_ok;
    v.exp_v = exp_v; v.exp_o = exp_o; v.exp_nfwd = exp_nfwd; v.exp_busy = exp_busy;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // src, text, gap_at, gap_len, chk_ok, verdict, overflow, forwarded chars, busy cycles
    vecs.push_back(mk(1'b0, "begin end",   0, 0, 1'b1, 1'b1, 1'b0, 9, 13));
    vecs.push_back(mk(1'b1, "abcdefghijk", 0, 0, 1'b1, 1'b0, 1'b1, 8, 13));
    vecs.push_back(mk(1'b0, "x",           0, 0, 1'b1, 1'b1, 1'b0, 1, 5));
    vecs.push_back(mk(1'b0, "begin;end",   4, 3, 1'b1, 1'b1, 1'b0, 9, 16));
    vecs.push_back(mk(1'b1, "end",         0, 0, 1'b0, 1'b0, 1'b0, 3, 7));
    vecs.push_back(mk(1'b0, "abcdefghi",   0, 0, 1'b0, 1'b0, 1'b0, 9, 13));
    vecs.push_back(mk(1'b1, "begin",       0, 0, 1'b1, 1'b1, 1'b0, 5, 9));

    s0_valid = 0; s0_data = 0; s0_last = 0;
    s1_valid = 0; s1_data = 0; s1_last = 0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_ready", {30'd0, s1_ready, s0_ready}, 0);
    check("rst_chk", {22'd0, chk_en, chk_clr, chk_data}, 0);
    check("rst_report", {28'd0, done, verdict, overflow}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      busy_cnt = 0;
      en_cnt = 0;
      send_msg(vecs[k].src, vecs[k].text, vecs[k].gap_at, vecs[k].gap_len, vecs[k].chk_ok,
               vecs[k].exp_v, vecs[k].exp_o, vecs[k].exp_nfwd);
      wait_idle();
      check("en_count", en_cnt, vecs[k].exp_nfwd);
      check("busy_cycles", busy_cnt, vecs[k].exp_busy);
      if (vecs[k].exp_o) begin
        check("ovf_done_lat", done_cyc - rep_acc, 1);
        check("ovf_clr_lat", clr_cyc - last_acc, 1);
      end else begin
        check("done_lat", done_cyc - rep_acc, SETTLE_CYC + 2);
        check("clr_lat", clr_cyc - done_cyc, 1);
      end
    end

    // Contention straight after reset, then again; then s0 alone so s1 wins the next tie.
    @(negedge clk) reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    contend(1'b0);
    contend(1'b0);
    send_msg(1'b0, "end", 0, 0, 1'b1, 1'b1, 1'b0, 3);
    wait_idle();
    contend(1'b1);

    // Reset in the middle of an s0 message.
    sb_chars = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, "q", 1'b0);
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_ready", {30'd0, s1_ready, s0_ready}, 0);
    check("midrst_chk_en", {31'd0, chk_en}, 0);
    check("midrst_chk_data", {24'd0, chk_data}, 0);
    check("midrst_report", {27'd0, chk_clr, done, verdict, overflow}, 0);
    drive(1'b0, 1'b0, 8'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    busy_cnt = 0;
    repeat (6) @(negedge clk);
    check("post_rst_idle", busy_cnt, 0);
    exp_chars.delete();
    sb_chars = 1'b1;
    contend(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
